bspi_slave: RTL
===============

BSPI_SLAVE -- requirements
Module: bspi_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the memory word-address width.
REQ-002 SHALL have parameter SYNC_N, default 2, the number of synchronizer flops on scs, sck and sdi.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port bcf, input, 1 bit: boot-config enable; frames are accepted only while it is high.
REQ-006 SHALL have port scs, input, 1 bit: SPI chip select, active-low, asynchronous.
REQ-007 SHALL have port sck, input, 1 bit: SPI clock, asynchronous; sdi is sampled on its rising edge.
REQ-008 SHALL have port sdi, input, 1 bit: serial data in, MSB first.
REQ-009 SHALL have port sdo, output, 1 bit: serial read data, MSB first.
REQ-010 SHALL have port mem_we, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port mem_re, output, 1 bit: one-cycle read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: word address.
REQ-013 SHALL have port mem_wdata, output, 32 bits: write data.
REQ-014 SHALL have port mem_rdata, input, 32 bits: read data, valid exactly 1 clk after mem_re.
REQ-015 SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-016 SHALL have port err, output, 1 bit: one-cycle pulse on an aborted or illegal frame.

Function
REQ-017 SHALL synchronize scs, sck and sdi through SYNC_N flops each.
REQ-018 SHALL detect sck edges from the synchronized sck history; the supported sck period is at least 4 clk periods.
REQ-019 SHALL use a frame of 16-bit header {cmd[1:0], rsv[2:0], addr[10:0]} followed by 32 data bits, 48 sck rising edges in total, MSB first.
REQ-020 SHALL decode cmd as follows: 2'b10 = write; 2'b11 = read; 2'b00 and 2'b01 = illegal. The rsv bits SHALL be ignored.
REQ-021 SHALL implement states IDLE, HDR, WR_DATA, RD_REQ, RD_WAIT, RD_DATA, DRAIN.
REQ-022 IDLE SHALL go to HDR when the synchronized scs falls while bcf is high; otherwise it SHALL stay in IDLE.
REQ-023 HDR SHALL shift in 16 bits using a 6-bit bit counter, then:
- go to WR_DATA for a write;
- go to RD_REQ for a read;
- for an illegal cmd, pulse err and go to DRAIN.
REQ-024 WR_DATA SHALL shift in 32 bits; on the 32nd bit it SHALL drive mem_we=1 for exactly one clk, with mem_addr=addr and mem_wdata equal to the shifted word, then go to DRAIN.
REQ-025 The mem_we strobe SHALL occur within 2 clk of the synchronized 48th sck rising edge.
REQ-026 RD_REQ SHALL pulse mem_re for one clk with mem_addr=addr, then go to RD_WAIT.
REQ-027 RD_WAIT SHALL load mem_rdata into the output shift register on the following clk, then go to RD_DATA.
REQ-028 In RD_DATA, sdo SHALL present data bit 31 before the first data sck rising edge.
REQ-029 In RD_DATA, sdo SHALL advance one bit on each synchronized sck falling edge; after 32 bits the block SHALL go to DRAIN.
REQ-030 DRAIN SHALL ignore sck and return to IDLE when the synchronized scs goes high.
REQ-031 A synchronized scs rise in HDR, WR_DATA, RD_REQ, RD_WAIT or RD_DATA SHALL abort the frame:
- no mem_we is issued;
- err pulses for one clk;
- the block returns to IDLE on the next clk.
REQ-032 A bcf fall mid-frame SHALL be treated the same as an scs rise, per REQ-031.
REQ-033 sck edges beyond bit 48 SHALL be ignored.
REQ-034 scs high for at least 2 clk SHALL suffice between back-to-back frames.
REQ-035 sdo SHALL be 0 in every state except RD_DATA.
REQ-036 busy SHALL be 1 in every state except IDLE.
REQ-037 mem_we and mem_re SHALL never be high in the same cycle.

Reset
REQ-038 While rst_n is low, the block SHALL be in IDLE with sdo, mem_we, mem_re, busy and err at 0, mem_addr at 0, mem_wdata at 0, and all synchronizer flops set so that scs=1, sck=1 and sdi=0.
REQ-039 rst_n asserted mid-frame SHALL drop the frame without issuing mem_we or err.
REQ-040 After rst_n is released, the block SHALL wait for a fresh scs fall before starting a frame.

Verification
REQ-041 Write frame: bcf=1, header 0x8000, data 0x00A00A13 -> one mem_we pulse with mem_addr=0x000 and mem_wdata=0x00A00A13; err=0.
REQ-042 Nine back-to-back writes to addresses 0x000-0x008 with scs high for 100 ns between frames -> nine mem_we pulses, each with the correct address and data, in order.
REQ-043 Read frame: header 0xC005, memory returns 0x30002004 -> one mem_re pulse with mem_addr=0x005, and sdo shifts out 0x30002004 MSB first.
REQ-044 Abort: scs raised after 20 bits of a write -> no mem_we, one err pulse, busy=0 within 3 clk.
REQ-045 Illegal command: header 0x4010 -> err pulse, no mem_we or mem_re, and the next valid frame succeeds.
REQ-046 bcf=0 during a write frame -> no strobes and busy=0; rst_n pulsed mid-frame -> all outputs 0 and a subsequent frame succeeds.

Source files
------------

// File: rtl/bspi_slave.sv
// Boot-config SPI slave: receives 48-bit frames (16-bit header + 32-bit data)
// over an asynchronous SPI link and turns them into single-word memory writes
// or reads. Every SPI input is synchronized into the clk domain. Edges are found
// from the synchronized history.
`timescale 1ns/1ps
module bspi_slave #(
  parameter int ADDR_W = 11,
  parameter int SYNC_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bcf,
  input  logic              scs,
  input  logic              sck,
  input  logic              sdi,
  output logic              sdo,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, HDR, WR_DATA, RD_REQ, RD_WAIT, RD_DATA, DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_N-1:0] scs_sync_q, scs_sync_d;
  logic [SYNC_N-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_N-1:0] sdi_sync_q, sdi_sync_d;
  logic              scs_prev_q, scs_prev_d;
  logic              sck_prev_q, sck_prev_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              err_q, err_d;

  logic scs_s, sck_s, sdi_s;
  logic scs_fall, sck_rise, sck_fall, abort;

  assign scs_s    = scs_sync_q[SYNC_N-1];
  assign sck_s    = sck_sync_q[SYNC_N-1];
  assign sdi_s    = sdi_sync_q[SYNC_N-1];
  assign scs_fall = scs_prev_q & ~scs_s;
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = sck_prev_q & ~sck_s;
  // A deselect or a dropped boot-config enable kills any frame still collecting
  assign abort    = scs_s | ~bcf;

  // Synchronizer chains and the one-deep history used for edge detection
  always_comb begin
    scs_sync_d    = scs_sync_q;
    sck_sync_d    = sck_sync_q;
    sdi_sync_d    = sdi_sync_q;
    scs_sync_d[0] = scs;
    sck_sync_d[0] = sck;
    sdi_sync_d[0] = sdi;
    for (int i = 1; i < SYNC_N; i++) begin
      scs_sync_d[i] = scs_sync_q[i-1];
      sck_sync_d[i] = sck_sync_q[i-1];
      sdi_sync_d[i] = sdi_sync_q[i-1];
    end
    scs_prev_d = scs_s;
    sck_prev_d = sck_s;
  end

  // Frame sequencing: shifting, header decode, memory strobes and abort handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (scs_fall && bcf) begin
          state_d   = HDR;
          bit_cnt_d = 6'd0;
        end
      end
      HDR: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d   = {shift_q[30:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd15) begin
            if (shift_q[14]) begin
              mem_addr_d = ADDR_W'({shift_q[9:0], sdi_s});
              state_d    = shift_q[13] ? RD_REQ : WR_DATA;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end
        end
      end
      WR_DATA: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          shift_d   = {shift_q[30:0], sdi_s};
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd47) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = {shift_q[30:0], sdi_s};
            state_d     = DRAIN;
          end
        end
      end
      RD_REQ: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          if (sck_rise) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      RD_WAIT: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          shift_d = mem_rdata;
          state_d = RD_DATA;
          if (sck_rise) bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      RD_DATA: begin
        // The trailing header fall must not shift away bit 31 before the master samples it
        if (abort) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == 6'd47) state_d = DRAIN;
        end else if (sck_fall && (bit_cnt_q > 6'd16)) begin
          shift_d = {shift_q[30:0], 1'b0};
        end
      end
      DRAIN: begin
        if (scs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset parks the synchronizers at an idle bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scs_sync_q  <= '1;
      sck_sync_q  <= '1;
      sdi_sync_q  <= '0;
      scs_prev_q  <= 1'b1;
      sck_prev_q  <= 1'b1;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scs_sync_q  <= scs_sync_d;
      sck_sync_q  <= sck_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      scs_prev_q  <= scs_prev_d;
      sck_prev_q  <= sck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
    end
  end

  assign sdo       = (state_q == RD_DATA) & shift_q[31];
  assign mem_re    = (state_q == RD_REQ);
  assign busy      = (state_q != IDLE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
